// File: rtl/branch_predictor_gshare.sv
// branch_predictor_gshare
// Dynamic branch predictor beside the Fetch-stage PC. A PHT of saturating
// counters (optionally indexed with PC XOR global history) supplies the
// direction; a tagged, valid-qualified BTB supplies the target. Trained by
// branches resolved in Execute.
//
// Ports:
//   CLK         clock, all state updates on rising edge
//   RESET       asynchronous active-high clear of all tables and history
//   PCF         Fetch-stage PC being looked up
//   PrPCSrcF    predicted taken (counter MSB and BTB hit)
//   PrBTAF      predicted target (0 on BTB miss)
//   PrHitF      BTB valid and tag match for PCF
//   UpdateE     a branch resolved in Execute this cycle
//   PCE         PC of the resolved branch
//   PCSrcE      actual outcome (1 = taken)
//   ALUResultE  actual branch target
module branch_predictor_gshare #(
   parameter int INDEX_WIDTH = 6,
   parameter int CTR_WIDTH   = 2,
   parameter int GHR_WIDTH   = 4,
   parameter int TAG_WIDTH   = 8
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] PCF,
   output logic        PrPCSrcF,
   output logic [31:0] PrBTAF,
   output logic        PrHitF,
   input  logic        UpdateE,
   input  logic [31:0] PCE,
   input  logic        PCSrcE,
   input  logic [31:0] ALUResultE
);

   localparam int DEPTH = 1 << INDEX_WIDTH;
   localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
   localparam logic [CTR_WIDTH-1:0] CTR_MAX  = CTR_WIDTH'((1 << CTR_WIDTH) - 1);
   localparam int TAG_LO = INDEX_WIDTH + 2;
   localparam int TAG_HI = INDEX_WIDTH + TAG_WIDTH + 1;

   logic [CTR_WIDTH-1:0] pht        [DEPTH];
   logic                 btb_valid  [DEPTH];
   logic [TAG_WIDTH-1:0] btb_tag    [DEPTH];
   logic [31:0]          btb_target [DEPTH];

   logic [INDEX_WIDTH-1:0] ghr_ext;
   logic [INDEX_WIDTH-1:0] idx_f, idx_e, pidx_f, pidx_e;
   logic [TAG_WIDTH-1:0]   tag_f, tag_e;

   // Only the index and tag fields of the PCs feed the tables.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{PCF, PCE};

   // Global history, zero-extended to index width; constant zero in bimodal mode.
   generate
      if (GHR_WIDTH > 0) begin : g_ghr
         logic [GHR_WIDTH-1:0] ghr;

         always_ff @(posedge CLK or posedge RESET) begin
            if (RESET) begin
               ghr <= '0;
            end else if (UpdateE) begin
               // Shift form also covers a 1-bit history (becomes PCSrcE).
               ghr <= (ghr << 1) | GHR_WIDTH'(PCSrcE);
            end
         end

         always_comb begin
            ghr_ext = '0;
            ghr_ext[GHR_WIDTH-1:0] = ghr;
         end
      end else begin : g_no_ghr
         assign ghr_ext = '0;
      end
   endgenerate

   assign idx_f  = PCF[INDEX_WIDTH+1:2];
   assign idx_e  = PCE[INDEX_WIDTH+1:2];
   assign tag_f  = PCF[TAG_HI:TAG_LO];
   assign tag_e  = PCE[TAG_HI:TAG_LO];
   assign pidx_f = idx_f ^ ghr_ext;
   assign pidx_e = idx_e ^ ghr_ext;

   // Lookup reads registered state only, so a same-cycle update is not bypassed.
   always_comb begin
      PrHitF   = btb_valid[idx_f] && (btb_tag[idx_f] == tag_f);
      PrPCSrcF = PrHitF && pht[pidx_f][CTR_WIDTH-1];
      PrBTAF   = PrHitF ? btb_target[idx_f] : 32'h0;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < DEPTH; i++) begin
            pht[i] <= CTR_INIT;
         end
      end else if (UpdateE) begin
         if (PCSrcE && (pht[pidx_e] != CTR_MAX)) begin
            pht[pidx_e] <= pht[pidx_e] + 1'b1;
         end else if (!PCSrcE && (pht[pidx_e] != '0)) begin
            pht[pidx_e] <= pht[pidx_e] - 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < DEPTH; i++) begin
            btb_valid[i]  <= 1'b0;
            btb_tag[i]    <= '0;
            btb_target[i] <= 32'h0;
         end
      end else if (UpdateE && PCSrcE) begin
         btb_valid[idx_e]  <= 1'b1;
         btb_tag[idx_e]    <= tag_e;
         btb_target[idx_e] <= ALUResultE;
      end
   end

endmodule

// File: doc/branch_predictor_gshare.md
# branch_predictor_gshare

Parametrised dynamic branch predictor for the pipelined ARMv3 core. It sits beside the Fetch-stage PC register and supplies a taken/not-taken prediction and a predicted target for the PC in Fetch. It is trained by branches resolved in Execute. It generalises the per-PC 1-entry predictor with the following:
- configurable-width saturating counters;
- optional global-history (gshare) indexing;
- a tagged, valid-qualified BTB;
- an asynchronous clear of all state.

## Interface
Parameters:
- INDEX_WIDTH, 6: log2 of PHT and BTB depth; index source is PC[INDEX_WIDTH+1:2].
- CTR_WIDTH, 2: saturating counter width, 1..4.
- GHR_WIDTH, 4: global history length, 0..INDEX_WIDTH; 0 selects pure bimodal mode (no GHR).
- TAG_WIDTH, 8: BTB tag width; tag = PC[INDEX_WIDTH+TAG_WIDTH+1:INDEX_WIDTH+2].

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- PCF  in  32  Fetch-stage PC being looked up.
- PrPCSrcF  out  1  predicted taken (counter MSB AND BTB hit).
- PrBTAF  out  32  predicted branch target (BTB entry target; 0 when no hit).
- PrHitF  out  1  BTB valid and tag match for PCF.
- UpdateE  in  1  a branch resolved in Execute this cycle; qualifies all training.
- PCE  in  32  PC of the resolved branch.
- PCSrcE  in  1  actual outcome (1 = taken).
- ALUResultE  in  32  actual branch target.

## Operation
- Tables:
  - PHT: 2^INDEX_WIDTH counters of CTR_WIDTH bits.
  - BTB: 2^INDEX_WIDTH entries of {valid, tag, target[31:0]}.
  - GHR: GHR_WIDTH bits (absent when GHR_WIDTH = 0).
- PHT index:
  - Fetch: PCF[INDEX_WIDTH+1:2] XOR zero-extended GHR.
  - Update: PCE[INDEX_WIDTH+1:2] XOR zero-extended GHR.
  - Both use the current GHR register value.
  - GHR_WIDTH = 0: no XOR.
- BTB index: PC[INDEX_WIDTH+1:2], never hashed.
- Lookup (combinational):
  - PrHitF = valid & (tag == PCF tag field).
  - PrPCSrcF = PrHitF & PHT[idx][CTR_WIDTH-1].
  - PrBTAF = PrHitF ? target : 32'h0.
- Training, on UpdateE = 1 at the clock edge:
  - Counter: PCSrcE = 1 increments, saturating at 2^CTR_WIDTH-1; PCSrcE = 0 decrements, saturating at 0.
  - BTB, PCSrcE = 1: entry gets valid = 1, the tag of PCE, and target = ALUResultE. This overwrites any aliasing entry, or the same entry with a new target.
  - BTB, PCSrcE = 0: entry unchanged.
  - GHR: becomes {GHR[GHR_WIDTH-2:0], PCSrcE}. For GHR_WIDTH = 1, GHR becomes PCSrcE.
- UpdateE = 0: no state changes.
- No read-after-write bypass. A Fetch lookup in the same cycle as an update to the same entry sees the pre-update contents. The new contents are visible from the next cycle.

## Timing
- Lookup latency is 0 cycles: outputs settle combinationally from PCF and state.
- Update latency is 1 cycle: state is written at the UpdateE edge and visible to lookups after that edge.
- RESET asserted (asynchronous, any time, including mid-update):
  - every counter = 2^(CTR_WIDTH-1)-1 (weakly not-taken; 1 for CTR_WIDTH = 2, 0 for CTR_WIDTH = 1);
  - every BTB valid = 0, tag = 0, target = 0;
  - GHR = 0.
- Outputs during and immediately after reset: PrHitF = 0, PrPCSrcF = 0, PrBTAF = 0 for any PCF.
- An update coinciding with the RESET edge is discarded.
- The first update is accepted on the first rising edge with RESET deasserted.
- Address wrap-around: PCs differing only above the tag field alias the same entry and tag. This is accepted; no detection.
- Counter saturation: repeated updates in the same direction hold the counter at its limit with no wrap.

## Test plan
- Reset: hold RESET for 3 cycles mid-run after training, then sweep PCF over all 64 indices -> PrHitF = 0, PrPCSrcF = 0, PrBTAF = 0 everywhere.
- Bimodal learning (GHR_WIDTH = 0):
  - Update PCE = 0x100, PCSrcE = 1, ALUResultE = 0x200 once -> PCF = 0x100 gives PrHitF = 1, PrBTAF = 0x200, PrPCSrcF = 1 (counter 1 -> 2).
  - One not-taken update -> PrPCSrcF = 0, PrHitF = 1.
- Saturation: 5 taken updates at 0x100, then 3 not-taken -> counter reaches 3, holds, then steps to 0. PrPCSrcF is 1 after 1 not-taken update and 0 after 2.
- Tag alias: train 0x100 to target 0x200, then look up 0x1100 (same index, different tag) -> PrHitF = 0. Train 0x1100 -> 0x300; 0x100 now misses.
- Gshare: GHR_WIDTH = 4. After 4 taken updates at 0x40, GHR = 4'b1111 -> the lookup of PCF = 0x40 reads PHT index 0x10 ^ 0xF = 0x1F. Verify PrPCSrcF follows PHT[0x1F], not PHT[0x10].
- Same-cycle collision: UpdateE at 0x100 (taken, 0x204) while PCF = 0x100 with the entry holding 0x200 -> PrBTAF = 0x200 in that cycle and 0x204 the next.
